// File: rtl/spi_oled_slave_pkg.sv
// Shared types and constants for the SPI OLED receiver: SSD1306 address-command
// decode and the layout of one queued receive entry.
package spi_oled_pkg;

  localparam logic [7:0] CMD_COL_LO      = 8'h00;
  localparam logic [7:0] CMD_COL_LO_MASK = 8'hF0;
  localparam logic [7:0] CMD_COL_HI      = 8'h10;
  localparam logic [7:0] CMD_COL_HI_MASK = 8'hF8;
  localparam logic [7:0] CMD_PAGE        = 8'hB0;
  localparam logic [7:0] CMD_PAGE_MASK   = 8'hF8;

  localparam int ENTRY_W = 1 + 8 + 7 + 3;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
    logic [6:0] col;
    logic [2:0] page;
  } rx_entry_t;

  typedef enum logic [1:0] {
    CMD_OTHER,
    CMD_SET_COL_LO,
    CMD_SET_COL_HI,
    CMD_SET_PAGE
  } cmd_kind_e;

  function automatic cmd_kind_e decode_cmd(input logic [7:0] b);
    cmd_kind_e k;
    k = CMD_OTHER;
    if ((b & CMD_COL_LO_MASK) == CMD_COL_LO)      k = CMD_SET_COL_LO;
    else if ((b & CMD_COL_HI_MASK) == CMD_COL_HI) k = CMD_SET_COL_HI;
    else if ((b & CMD_PAGE_MASK) == CMD_PAGE)     k = CMD_SET_PAGE;
    return k;
  endfunction

endpackage

// File: rtl/spi_oled_slave_if.sv
// SPI pins plus the receive-side valid/ready port of the OLED receiver.
// Handshake: an entry transfers on any clk edge where rx_valid && rx_ready;
// rx_valid never depends on rx_ready, and rx_ready with rx_valid low is ignored.
interface spi_oled_slave_if;
  logic       spi_cs;
  logic       spi_sck;
  logic       spi_dc;
  logic       spi_mosi;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic [6:0] rx_col;
  logic [2:0] rx_page;
  logic       frame_err;
  logic       overflow;

  modport slave (
    input  spi_cs, spi_sck, spi_dc, spi_mosi, rx_ready,
    output rx_valid, rx_data, rx_dc, rx_col, rx_page, frame_err, overflow
  );

  modport master (
    output spi_cs, spi_sck, spi_dc, spi_mosi, rx_ready,
    input  rx_valid, rx_data, rx_dc, rx_col, rx_page, frame_err, overflow
  );
endinterface

// File: rtl/spi_oled_slave_sync_fifo.sv
// Show-ahead synchronous FIFO: o_data is the head whenever o_empty is low.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/spi_oled_slave.sv
// SPI mode-0 receiver for the OLED link: oversampled pins, MSB-first byte
// assembly, GDDRAM column/page tracking and a tagged output FIFO.
module spi_oled_slave
  import spi_oled_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COLS       = 128,
  parameter int PAGES      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_oled_slave_if.slave  bus
);
  localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
  localparam logic [2:0] LAST_PAGE = 3'(PAGES - 1);

  logic [1:0] r_cs_sync;
  logic [1:0] r_sck_sync;
  logic [1:0] r_dc_sync;
  logic [1:0] r_mosi_sync;
  logic       w_cs;
  logic       w_sck;

  logic       r_cs_d;
  logic       r_sck_d;
  logic       r_sck_rise;
  logic       r_cs_rise;
  logic       r_cs_fall;
  logic       r_dc_d;
  logic       r_mosi_d;

  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic       w_frame_err;
  logic       r_frame_err;

  logic [6:0] r_col;
  logic [2:0] r_page;
  rx_entry_t  w_entry;
  cmd_kind_e  w_cmd;

  logic [ENTRY_W-1:0] w_head;
  rx_entry_t          w_out;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               r_overflow;

  // CS synchronizer resets high so a released reset never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_sync   <= 2'b11;
      r_sck_sync  <= 2'b00;
      r_dc_sync   <= 2'b00;
      r_mosi_sync <= 2'b00;
    end else begin
      r_cs_sync   <= {r_cs_sync[0],   bus.spi_cs};
      r_sck_sync  <= {r_sck_sync[0],  bus.spi_sck};
      r_dc_sync   <= {r_dc_sync[0],   bus.spi_dc};
      r_mosi_sync <= {r_mosi_sync[0], bus.spi_mosi};
    end
  end

  assign w_cs  = r_cs_sync[1];
  assign w_sck = r_sck_sync[1];

  // Edge stage: DC/MOSI are registered alongside the edge flags to stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_d     <= 1'b1;
      r_sck_d    <= 1'b0;
      r_sck_rise <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_dc_d     <= 1'b0;
      r_mosi_d   <= 1'b0;
    end else begin
      r_cs_d     <= w_cs;
      r_sck_d    <= w_sck;
      r_sck_rise <= w_sck & ~r_sck_d;
      r_cs_rise  <= w_cs & ~r_cs_d;
      r_cs_fall  <= ~w_cs & r_cs_d;
      r_dc_d     <= r_dc_sync[1];
      r_mosi_d   <= r_mosi_sync[1];
    end
  end

  assign w_byte      = {r_shift[6:0], r_mosi_d};
  assign w_byte_done = r_sck_rise && !r_cs_d && !r_cs_fall && (r_bit_cnt == 3'd7);
  assign w_frame_err = r_cs_rise && (r_bit_cnt != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      if (r_cs_d || r_cs_fall) begin
        r_bit_cnt <= '0;
      end else if (r_sck_rise) begin
        r_shift   <= w_byte;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  assign w_cmd        = decode_cmd(w_byte);
  assign w_entry.dc   = r_dc_d;
  assign w_entry.data = w_byte;
  assign w_entry.col  = r_col;
  assign w_entry.page = r_page;

  // The address advances on every completed byte, even one the FIFO drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_page <= '0;
    end else if (w_byte_done) begin
      if (r_dc_d) begin
        if (r_col == LAST_COL) begin
          r_col  <= '0;
          r_page <= (r_page == LAST_PAGE) ? 3'd0 : r_page + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else begin
        case (w_cmd)
          CMD_SET_COL_LO: r_col[3:0] <= w_byte[3:0];
          CMD_SET_COL_HI: r_col[6:4] <= w_byte[2:0];
          CMD_SET_PAGE:   r_page     <= w_byte[2:0];
          default:        ;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_byte_done),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop = !w_empty && bus.rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_byte_done && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // Outputs read as zero while empty so the idle bus matches the reset state.
  assign w_out         = w_empty ? '0 : rx_entry_t'(w_head);
  assign bus.rx_valid  = !w_empty;
  assign bus.rx_data   = w_out.data;
  assign bus.rx_dc     = w_out.dc;
  assign bus.rx_col    = w_out.col;
  assign bus.rx_page   = w_out.page;
  assign bus.frame_err = r_frame_err;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_spi_oled_slave.sv
// Directed bench for spi_oled_slave: SPI master driver tasks, tagged-entry
// scoreboard with hand-computed expected entries, and a final report.
module tb_spi_oled_slave;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   ferr_cnt;
  logic [18:0] exp_q[$];

  spi_oled_slave_if bus();

  spi_oled_slave #(
    .FIFO_DEPTH (4),
    .COLS       (128),
    .PAGES      (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] mk(input logic dc, input logic [7:0] d,
                                      input logic [6:0] c, input logic [2:0] p);
    return {dc, d, c, p};
  endfunction

  // scoreboard: every accepted entry is compared to the queue head
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid && bus.rx_ready) begin
      if (exp_q.size() == 0)
        chk("unexpected_pop", exp_q.size(), 1);
      else
        chk("entry", {bus.rx_dc, bus.rx_data, bus.rx_col, bus.rx_page}, exp_q.pop_front());
    end
    if (bus.frame_err) ferr_cnt++;
  end

  // driver tasks (entered and left at posedge+1)
  task automatic send_byte(input logic dc, input logic [7:0] d, input int nbits,
                           input bit pop_on_last);
    for (int i = 0; i < nbits; i++) begin
      bus.spi_dc   = dc;
      bus.spi_mosi = d[7-i];
      repeat (4) @(posedge clk);
      #1;
      bus.spi_sck = 1'b1;
      if (pop_on_last && i == nbits - 1) begin
        repeat (3) @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        @(posedge clk);
        #1 bus.rx_ready = 1'b0;
      end else begin
        repeat (4) @(posedge clk);
        #1;
      end
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    bus.spi_cs = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic cs_end();
    repeat (4) @(posedge clk);
    #1 bus.spi_cs = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
    chk("drain_empty", bus.rx_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0; ferr_cnt = 0;
    rst_n = 1'b0;
    bus.spi_cs = 1'b1; bus.spi_sck = 1'b0; bus.spi_dc = 1'b0; bus.spi_mosi = 1'b0;
    bus.rx_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_data", bus.rx_data, 8'h00);
    chk("rst_dc", bus.rx_dc, 0);
    chk("rst_col", bus.rx_col, 0);
    chk("rst_page", bus.rx_page, 0);
    chk("rst_ferr", bus.frame_err, 0);
    chk("rst_ovf", bus.overflow, 0);
    @(posedge clk);
    #1;

    // 0xAF command with latency measured from the 8th SCK rising edge
    cs_begin();
    send_byte(1'b0, 8'hAF, 7, 1'b0);
    bus.spi_mosi = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    chk("lat_3clk", bus.rx_valid, 0);
    @(negedge clk);
    chk("lat_4clk", bus.rx_valid, 1);
    chk("head_af", {bus.rx_dc, bus.rx_data, bus.rx_col, bus.rx_page}, mk(1'b0, 8'hAF, 7'h00, 3'd0));
    @(posedge clk);
    #1 bus.spi_sck = 1'b0;
    cs_end();
    exp_q.push_back(mk(1'b0, 8'hAF, 7'h00, 3'd0));
    bus.rx_ready = 1'b1;
    wait_drain();

    // page/column set, then two data bytes
    exp_q.push_back(mk(1'b0, 8'hB3, 7'h00, 3'd0));
    exp_q.push_back(mk(1'b0, 8'h05, 7'h00, 3'd3));
    exp_q.push_back(mk(1'b0, 8'h12, 7'h05, 3'd3));
    exp_q.push_back(mk(1'b1, 8'h55, 7'h25, 3'd3));
    exp_q.push_back(mk(1'b1, 8'hAA, 7'h26, 3'd3));
    cs_begin();
    send_byte(1'b0, 8'hB3, 8, 1'b0);
    send_byte(1'b0, 8'h05, 8, 1'b0);
    send_byte(1'b0, 8'h12, 8, 1'b0);
    send_byte(1'b1, 8'h55, 8, 1'b0);
    send_byte(1'b1, 8'hAA, 8, 1'b0);
    cs_end();
    wait_drain();

    // column 127 on page 7, then data wraps both counters
    exp_q.push_back(mk(1'b0, 8'hB7, 7'h27, 3'd3));
    exp_q.push_back(mk(1'b0, 8'h0F, 7'h27, 3'd7));
    exp_q.push_back(mk(1'b0, 8'h17, 7'h2F, 3'd7));
    exp_q.push_back(mk(1'b1, 8'h01, 7'h7F, 3'd7));
    exp_q.push_back(mk(1'b1, 8'h02, 7'h00, 3'd0));
    cs_begin();
    send_byte(1'b0, 8'hB7, 8, 1'b0);
    send_byte(1'b0, 8'h0F, 8, 1'b0);
    send_byte(1'b0, 8'h17, 8, 1'b0);
    send_byte(1'b1, 8'h01, 8, 1'b0);
    send_byte(1'b1, 8'h02, 8, 1'b0);
    cs_end();
    wait_drain();
    chk("ferr_none_yet", ferr_cnt, 0);

    // partial frame, then a clean command
    cs_begin();
    send_byte(1'b0, 8'hFF, 5, 1'b0);
    cs_end();
    chk("ferr_once", ferr_cnt, 1);
    exp_q.push_back(mk(1'b0, 8'h3C, 7'h01, 3'd0));
    cs_begin();
    send_byte(1'b0, 8'h3C, 8, 1'b0);
    cs_end();
    wait_drain();
    chk("ferr_still_once", ferr_cnt, 1);

    // fill, push+pop while full, then a dropped byte
    bus.rx_ready = 1'b0;
    exp_q.push_back(mk(1'b1, 8'hD0, 7'h01, 3'd0));
    exp_q.push_back(mk(1'b1, 8'hD1, 7'h02, 3'd0));
    exp_q.push_back(mk(1'b1, 8'hD2, 7'h03, 3'd0));
    exp_q.push_back(mk(1'b1, 8'hD3, 7'h04, 3'd0));
    exp_q.push_back(mk(1'b1, 8'hD4, 7'h05, 3'd0));
    cs_begin();
    send_byte(1'b1, 8'hD0, 8, 1'b0);
    send_byte(1'b1, 8'hD1, 8, 1'b0);
    send_byte(1'b1, 8'hD2, 8, 1'b0);
    send_byte(1'b1, 8'hD3, 8, 1'b0);
    @(negedge clk);
    chk("full_valid", bus.rx_valid, 1);
    chk("full_no_ovf", bus.overflow, 0);
    @(posedge clk);
    #1;
    send_byte(1'b1, 8'hD4, 8, 1'b1);
    @(negedge clk);
    chk("pushpop_no_ovf", bus.overflow, 0);
    chk("pushpop_left", exp_q.size(), 4);
    @(posedge clk);
    #1;
    send_byte(1'b1, 8'hD5, 8, 1'b0);
    @(negedge clk);
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_head", {bus.rx_dc, bus.rx_data, bus.rx_col, bus.rx_page}, mk(1'b1, 8'hD1, 7'h02, 3'd0));
    @(posedge clk);
    #1;
    cs_end();
    bus.rx_ready = 1'b1;
    wait_drain();
    chk("ovf_sticky", bus.overflow, 1);

    // address kept advancing through the dropped byte
    exp_q.push_back(mk(1'b1, 8'h77, 7'h07, 3'd0));
    cs_begin();
    send_byte(1'b1, 8'h77, 8, 1'b0);
    cs_end();
    wait_drain();

    // reset mid-byte with two entries queued
    bus.rx_ready = 1'b0;
    ferr_cnt = 0;
    cs_begin();
    send_byte(1'b1, 8'h61, 8, 1'b0);
    send_byte(1'b1, 8'h62, 8, 1'b0);
    send_byte(1'b1, 8'hFF, 4, 1'b0);
    @(negedge clk);
    chk("pre_rst_head", {bus.rx_dc, bus.rx_data, bus.rx_col, bus.rx_page}, mk(1'b1, 8'h61, 7'h08, 3'd0));
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", bus.rx_valid, 0);
    chk("mid_rst_data", bus.rx_data, 8'h00);
    chk("mid_rst_dc", bus.rx_dc, 0);
    chk("mid_rst_col", bus.rx_col, 0);
    chk("mid_rst_page", bus.rx_page, 0);
    chk("mid_rst_ovf", bus.overflow, 0);
    chk("mid_rst_ferr", bus.frame_err, 0);
    bus.spi_cs = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    exp_q.push_back(mk(1'b0, 8'hA5, 7'h00, 3'd0));
    exp_q.push_back(mk(1'b1, 8'h3E, 7'h00, 3'd0));
    bus.rx_ready = 1'b1;
    cs_begin();
    send_byte(1'b0, 8'hA5, 8, 1'b0);
    send_byte(1'b1, 8'h3E, 8, 1'b0);
    cs_end();
    wait_drain();
    chk("rst_no_ferr", ferr_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
